// File: rtl/byte_unstriping_pkg.sv
// Shared definitions for the byte unstriping block: lane count, default
// widths and the serializer state encoding.
package byte_unstriping_pkg;

  localparam int LANES     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/byte_unstriping_lane_fifo.sv
// Per-lane deskew FIFO. One clock, DEPTH entries (power of two).
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_push/i_pop   write/read strobes; a push on a full FIFO is taken only
//                  when the same edge pops
//   i_data_in      write data
//   o_data_out     head entry (combinational read)
//   o_count        registered occupancy, 0..DEPTH
//   o_full/o_empty occupancy flags derived from o_count
module byte_unstriping_lane_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data_in,
  output logic [WIDTH-1:0]         o_data_out,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok, w_pop_ok;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_data_out = r_mem[r_rptr];

  // A simultaneous pop frees the slot the push lands in.
  assign w_push_ok = i_push & (~o_full | i_pop);
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data_in;
  end

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/byte_unstriping.sv
// Four-lane receive reassembly. Each lane's bytes are deskewed in a small
// FIFO; once every lane holds a byte, one byte per lane is popped into a
// holding register and emitted in lane order 0,1,2,3.
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_lane0_in..i_lane3_in lane bytes
//   i_lane_valid           bit i qualifies lane i this cycle
//   o_data_out             reassembled byte (0 when o_valid_out low)
//   o_valid_out            o_data_out carries a byte
//   o_overflow             sticky: a lane byte was dropped on a full FIFO
//   o_busy                 serializer is emitting a group
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_lane0_in,
  input  logic [WIDTH-1:0] i_lane1_in,
  input  logic [WIDTH-1:0] i_lane2_in,
  input  logic [WIDTH-1:0] i_lane3_in,
  input  logic [LANES-1:0] i_lane_valid,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid_out,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [LANES-1:0][WIDTH-1:0] w_lane_in, w_fifo_dout;
  logic [LANES-1:0][CW-1:0]    w_count;
  logic [LANES-1:0]            w_full, w_empty;
  logic                        w_ready, w_pop;
  logic                        w_unused;

  state_t                      r_state, w_state_nxt;
  logic [1:0]                  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [LANES-1:0][WIDTH-1:0] r_hold, w_hold_nxt;
  logic [WIDTH-1:0]            r_data, w_data_nxt;
  logic                        r_ovf;

  assign w_lane_in = {i_lane3_in, i_lane2_in, i_lane1_in, i_lane0_in};
  assign w_unused  = ^w_empty;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    byte_unstriping_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push     (i_lane_valid[gi]),
      .i_pop      (w_pop),
      .i_data_in  (w_lane_in[gi]),
      .o_data_out (w_fifo_dout[gi]),
      .o_count    (w_count[gi]),
      .o_full     (w_full[gi]),
      .o_empty    (w_empty[gi])
    );
  end

  // Group ready: every lane holds at least one byte.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < LANES; i++)
      if (w_count[i] == '0) w_ready = 1'b0;
  end

  // Next-state logic. A pop happens from IDLE, or on the last byte of a
  // group so the next group follows with no gap.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (r_cnt == 2'd3) begin
          if (w_ready) w_pop = 1'b1;
          else         w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next registered outputs. The byte for counter=0 comes straight from
  // the FIFO heads so lane 0 appears on the same edge as the pop.
  assign w_cnt_inc = r_cnt + 2'd1;

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_hold_nxt = r_hold;
    w_data_nxt = '0;
    if (w_pop) begin
      w_hold_nxt = w_fifo_dout;
      w_cnt_nxt  = 2'd0;
      w_data_nxt = w_fifo_dout[0];
    end else if (w_state_nxt == ST_EMIT) begin
      w_cnt_nxt  = w_cnt_inc;
      w_data_nxt = r_hold[w_cnt_inc];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      r_data  <= w_data_nxt;
      // Drop: valid on a full lane whose FIFO is not popped this edge.
      r_ovf   <= r_ovf | (|(i_lane_valid & w_full & ~{LANES{w_pop}}));
    end
  end

  assign o_data_out  = r_data;
  assign o_valid_out = (r_state == ST_EMIT);
  assign o_busy      = (r_state == ST_EMIT);
  assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_byte_unstriping.sv
module tb_byte_unstriping;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] l0, l1, l2, l3;
  logic [3:0]   lv;
  logic [W-1:0] data_out;
  logic         valid_out, ovf_out, busy_out;

  int checks = 0;
  int failures = 0;

  byte_unstriping #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lane0_in   (l0),
    .i_lane1_in   (l1),
    .i_lane2_in   (l2),
    .i_lane3_in   (l3),
    .i_lane_valid (lv),
    .o_data_out   (data_out),
    .o_valid_out  (valid_out),
    .o_overflow   (ovf_out),
    .o_busy       (busy_out)
  );

  always #5 clk = ~clk;

  // Reference model: per-lane queues, the group being emitted and how many
  // of its bytes remain to be shown (including the one now on the output).
  logic [W-1:0] mq [4][$];
  logic [W-1:0] grp [4];
  int           left;
  bit           movf;
  logic [W-1:0] cap [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      grp[i] = '0;
    end
    left = 0;
    movf = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] m, input logic [3:0][W-1:0] b);
    bit all_ne = 1'b1;
    for (int i = 0; i < 4; i++) if (mq[i].size() == 0) all_ne = 1'b0;
    if (all_ne && left <= 1) begin
      for (int i = 0; i < 4; i++) grp[i] = mq[i].pop_front();
      left = 4;
    end else if (left > 0) begin
      left--;
    end
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        if (mq[i].size() < D) mq[i].push_back(b[i]);
        else movf = 1'b1;
      end
  endtask

  // One clock: drive lanes, step model at the edge, compare just after it.
  task automatic cyc(input logic [3:0] m, input logic [W-1:0] b0, b1, b2, b3);
    logic [W-1:0] edata;
    logic         evld;
    lv = m; l0 = b0; l1 = b1; l2 = b2; l3 = b3;
    @(posedge clk);
    model_edge(m, {b3, b2, b1, b0});
    #1;
    evld  = (left > 0);
    edata = evld ? grp[4 - left] : '0;
    chk("model_cyc", {21'd0, ovf_out, busy_out, valid_out, data_out},
                     {21'd0, movf, evld, evld, edata});
    if (valid_out) cap.push_back(data_out);
    lv = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'h0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    lv = '0;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_state", {ovf_out, busy_out, valid_out, data_out}, '0);
    #1 rst = 1'b0;
    cap.delete();
  endtask

  typedef struct {
    logic [3:0][W-1:0] lanes;
    logic [3:0][W-1:0] exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [W-1:0] expq [$];
    rst = 1'b1; lv = '0; l0 = '0; l1 = '0; l2 = '0; l3 = '0;
    model_clear();
    #2;
    chk("reset_data", {24'd0, data_out}, 32'd0);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    chk("reset_ovf", {31'd0, ovf_out}, 32'd0);
    chk("reset_busy", {31'd0, busy_out}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Aligned groups: lane i byte is element i, emitted in lane order.
    tbl[0].lanes = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; tbl[0].exp = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tbl[1].lanes = {8'hFF, 8'h00, 8'hFF, 8'h00}; tbl[1].exp = {8'hFF, 8'h00, 8'hFF, 8'h00};
    tbl[2].lanes = {8'h01, 8'h02, 8'h03, 8'h04}; tbl[2].exp = {8'h01, 8'h02, 8'h03, 8'h04};
    tbl[3].lanes = {8'h5A, 8'hC3, 8'h7E, 8'h81}; tbl[3].exp = {8'h5A, 8'hC3, 8'h7E, 8'h81};
    for (int t = 0; t < 4; t++) begin
      cyc(4'hF, tbl[t].lanes[0], tbl[t].lanes[1], tbl[t].lanes[2], tbl[t].lanes[3]);
      chk("tbl_push_quiet", {31'd0, valid_out}, 32'd0);
      for (int j = 0; j < 4; j++) begin
        idle(1);
        chk("tbl_data", {24'd0, data_out}, {24'd0, tbl[t].exp[j]});
        chk("tbl_valid", {31'd0, valid_out}, 32'd1);
      end
      idle(1);
      chk("tbl_end_valid", {30'd0, valid_out, busy_out}, 32'd0);
      chk("tbl_end_data", {24'd0, data_out}, 32'd0);
    end

    // Skew: lanes 0,1 one edge ahead of lanes 2,3.
    do_reset();
    cyc(4'b0011, 8'h11, 8'h22, 8'h00, 8'h00);
    cyc(4'b1100, 8'h00, 8'h00, 8'h33, 8'h44);
    chk("skew_wait", {31'd0, valid_out}, 32'd0);
    idle(1); chk("skew_b0", {24'd0, data_out}, 32'h11);
    idle(1); chk("skew_b1", {24'd0, data_out}, 32'h22);
    idle(1); chk("skew_b2", {24'd0, data_out}, 32'h33);
    idle(1); chk("skew_b3", {24'd0, data_out}, 32'h44);
    chk("skew_ovf", {31'd0, ovf_out}, 32'd0);

    // Back-to-back groups every 4 cycles: 12 contiguous bytes.
    do_reset();
    expq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
             8'h30, 8'h31, 8'h32, 8'h33};
    for (int t = 0; t <= 12; t++) begin
      if (t % 4 == 0 && t < 12) begin
        logic [W-1:0] base;
        base = 8'((t / 4 + 1) * 16);
        cyc(4'hF, base, base + 8'd1, base + 8'd2, base + 8'd3);
      end else begin
        idle(1);
      end
      if (t >= 1) begin
        chk("b2b_data", {24'd0, data_out}, {24'd0, expq[t-1]});
        chk("b2b_busy", {30'd0, busy_out, valid_out}, 32'd3);
      end
    end
    idle(1);
    chk("b2b_done", {31'd0, busy_out}, 32'd0);

    // Overflow: third lane-2 byte is dropped and the flag sticks.
    do_reset();
    cyc(4'b0100, 8'h00, 8'h00, 8'h51, 8'h00);
    cyc(4'b0100, 8'h00, 8'h00, 8'h52, 8'h00);
    chk("ovf_not_yet", {31'd0, ovf_out}, 32'd0);
    cyc(4'b0100, 8'h00, 8'h00, 8'h53, 8'h00);
    chk("ovf_set", {31'd0, ovf_out}, 32'd1);
    cyc(4'b1011, 8'h60, 8'h61, 8'h00, 8'h63);
    cyc(4'b1011, 8'h70, 8'h71, 8'h00, 8'h73);
    idle(10);
    expq = '{8'h60, 8'h61, 8'h51, 8'h63, 8'h70, 8'h71, 8'h52, 8'h73};
    chk("ovf_count", cap.size(), 8);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      chk("ovf_stream", {24'd0, cap[i]}, {24'd0, expq[i]});
    chk("ovf_sticky", {31'd0, ovf_out}, 32'd1);
    do_reset();
    chk("ovf_cleared", {31'd0, ovf_out}, 32'd0);

    // Reset in the middle of a group.
    cyc(4'hF, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
    idle(2);
    chk("mid_b1", {24'd0, data_out}, 32'hC1);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_now", {22'd0, busy_out, valid_out, data_out}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(2);
    chk("mid_quiet", {31'd0, valid_out}, 32'd0);
    cyc(4'hF, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    idle(1);
    chk("mid_after_b0", {24'd0, data_out}, 32'hD0);
    idle(4);

    // Random: sparse skewed traffic, then dense traffic that overflows.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] m;
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cyc(m, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    do_reset();
    for (int n = 0; n < 600; n++)
      cyc(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
